ctx_mem_arbiter: RTL and testbench

Shares the core's OBI data-memory port between the CV32E40P LSU and the RTOSUnit context-save/restore engine. It arbitrates with core priority plus a starvation guard, and holds the address phase stable until grant. An in-order outstanding-transaction FIFO routes each response back to the requester that issued it. It sits between the core/RTOSUnit and the data memory in the simulation/SoC wrappers.

---
 rtl/ctx_mem_arbiter_pkg.sv | 15 +
 rtl/ctx_mem_arbiter_if.sv | 50 +++++
 rtl/ctx_mem_tag_fifo.sv | 49 ++++
 rtl/ctx_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_ctx_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctx_mem_arbiter_pkg.sv
// rtl/ctx_mem_arbiter_pkg.sv - shared types for the core/context data-memory arbiter
package ctx_mem_arb_pkg;

  typedef enum logic {SRC_CORE = 1'b0, SRC_CTX = 1'b1} src_e;

  typedef struct packed {
    src_e src;
    logic is_read;
  } rsp_tag_t;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_e;

  localparam logic [3:0] CTX_BE = 4'hF;

endpackage

// File: rtl/ctx_mem_arbiter_if.sv
// rtl/ctx_mem_arbiter_if.sv - core, context-engine and data-memory OBI signal bundle
interface ctx_mem_arbiter_if #(parameter int MAX_OUTSTANDING = 4);

  logic        core_req_i;
  logic        core_gnt_o;
  logic        core_we_i;
  logic [3:0]  core_be_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wdata_i;
  logic        core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        ctx_valid_i;
  logic        ctx_ready_o;
  logic        ctx_we_i;
  logic [31:0] ctx_addr_i;
  logic [31:0] ctx_wdata_i;
  logic        ctx_rvalid_o;
  logic [31:0] ctx_rdata_o;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;
  logic [$clog2(MAX_OUTSTANDING):0] outstanding_o;
  logic        err_o;

  modport slave (
    input  core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
    input  ctx_valid_i, ctx_we_i, ctx_addr_i, ctx_wdata_i,
    input  data_gnt_i, data_rvalid_i, data_rdata_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o,
    output ctx_ready_o, ctx_rvalid_o, ctx_rdata_o,
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output outstanding_o, err_o
  );

  modport master (
    output core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
    output ctx_valid_i, ctx_we_i, ctx_addr_i, ctx_wdata_i,
    output data_gnt_i, data_rvalid_i, data_rdata_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o,
    input  ctx_ready_o, ctx_rvalid_o, ctx_rdata_o,
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  outstanding_o, err_o
  );

endinterface

// File: rtl/ctx_mem_tag_fifo.sv
// rtl/ctx_mem_tag_fifo.sv - in-order FIFO of response-routing tags
module ctx_mem_tag_fifo
  import ctx_mem_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  rsp_tag_t      push_data,
  input  logic          pop,
  output rsp_tag_t      head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  rsp_tag_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ctx_mem_arbiter.sv
// rtl/ctx_mem_arbiter.sv - shares the data-memory OBI port between core LSU and context engine
module ctx_mem_arbiter
  import ctx_mem_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8,
  parameter int RSP_REG         = 1
) (
  input logic              clk_i,
  input logic              rst_i,
  ctx_mem_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e     state;
  src_e           owner;
  src_e           cur_src;
  logic           req_active;
  logic           handshake;
  logic [SW-1:0]  starve_cnt;
  logic           starved;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  rsp_tag_t       push_tag;
  rsp_tag_t       head;
  logic           rsp_valid;
  logic [31:0]    rsp_data;
  logic           pop;
  logic           err;

  assign starved = (starve_cnt == STARVE_MAX);

  // A held (LOCKED) address phase always wins; a new one never starts into a full FIFO.
  always_comb begin
    cur_src    = SRC_CORE;
    req_active = 1'b0;
    if (state == LOCKED) begin
      cur_src    = owner;
      req_active = 1'b1;
    end else if (!fifo_full) begin
      if (bus.core_req_i && !starved) begin
        cur_src    = SRC_CORE;
        req_active = 1'b1;
      end else if (bus.ctx_valid_i) begin
        cur_src    = SRC_CTX;
        req_active = 1'b1;
      end else if (bus.core_req_i) begin
        cur_src    = SRC_CORE;
        req_active = 1'b1;
      end
    end
  end

  assign handshake        = req_active && bus.data_gnt_i;
  assign bus.data_req_o   = req_active;
  assign bus.data_we_o    = req_active && ((cur_src == SRC_CTX) ? bus.ctx_we_i : bus.core_we_i);
  assign bus.data_be_o    = !req_active ? 4'h0 : ((cur_src == SRC_CTX) ? CTX_BE : bus.core_be_i);
  assign bus.data_addr_o  = !req_active ? 32'h0 : ((cur_src == SRC_CTX) ? bus.ctx_addr_i : bus.core_addr_i);
  assign bus.data_wdata_o = !req_active ? 32'h0 : ((cur_src == SRC_CTX) ? bus.ctx_wdata_i : bus.core_wdata_i);
  assign bus.core_gnt_o   = handshake && (cur_src == SRC_CORE);
  assign bus.ctx_ready_o  = handshake && (cur_src == SRC_CTX);

  assign push_tag.src     = cur_src;
  assign push_tag.is_read = !bus.data_we_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      owner <= SRC_CORE;
    end else if (state == IDLE) begin
      if (req_active && !bus.data_gnt_i) begin
        state <= LOCKED;
        owner <= cur_src;
      end
    end else if (bus.data_gnt_i) begin
      state <= IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !bus.ctx_valid_i || bus.ctx_ready_o) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  generate
    if (RSP_REG != 0) begin : g_rsp_reg
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rsp_valid <= 1'b0;
          rsp_data  <= '0;
        end else begin
          rsp_valid <= bus.data_rvalid_i;
          rsp_data  <= bus.data_rdata_i;
        end
      end
    end else begin : g_rsp_comb
      assign rsp_valid = bus.data_rvalid_i;
      assign rsp_data  = bus.data_rdata_i;
    end
  endgenerate

  ctx_mem_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (handshake),
    .push_data (push_tag),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Responses with nothing outstanding are swallowed and flagged, never forwarded.
  assign pop = rsp_valid && !fifo_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err <= 1'b0;
    end else if (rsp_valid && fifo_empty) begin
      err <= 1'b1;
    end
  end

  assign bus.core_rvalid_o = pop && (head.src == SRC_CORE);
  assign bus.ctx_rvalid_o  = pop && (head.src == SRC_CTX) && head.is_read;
  assign bus.core_rdata_o  = rsp_data;
  assign bus.ctx_rdata_o   = rsp_data;
  assign bus.outstanding_o = fifo_count;
  assign bus.err_o         = err;

endmodule

// File: tb/tb_ctx_mem_arbiter.sv
// tb/tb_ctx_mem_arbiter.sv - self-checking bench for ctx_mem_arbiter
module tb_ctx_mem_arbiter;

  localparam int MAXO = 4;
  localparam int SLIM = 8;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctx_mem_arbiter_if #(.MAX_OUTSTANDING(MAXO)) bus ();

  ctx_mem_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SLIM), .RSP_REG(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic creq; logic cwe; logic [3:0] cbe; logic [31:0] caddr; logic [31:0] cwdata;
    logic xval; logic xwe; logic [31:0] xaddr; logic [31:0] xwdata; logic gnt;
    logic req; logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;
    logic cgnt; logic xrdy;
  } vec_t;

  typedef struct { bit is_core; bit is_read; } tag_m;

  tag_m        tq[$];
  int          mem_pending;
  bit          m_locked;
  bit          m_owner_ctx;
  int          wait_cnt;
  bit          p_rsp;
  logic [31:0] p_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.core_req_i = 0; bus.core_we_i = 0; bus.core_be_i = 4'h0;
    bus.core_addr_i = 32'h0; bus.core_wdata_i = 32'h0;
    bus.ctx_valid_i = 0; bus.ctx_we_i = 0; bus.ctx_addr_i = 32'h0; bus.ctx_wdata_i = 32'h0;
    bus.data_gnt_i = 0; bus.data_rvalid_i = 0; bus.data_rdata_i = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One randomized cycle: drive, compare against the rule-level model, then advance it.
  task automatic rnd_cycle(input bit allow_new);
    bit exp_req, exp_ctx, exp_cv, exp_xv, hs, rd, drop_core, drop_ctx;
    if (allow_new && !bus.core_req_i && $urandom_range(0, 1) == 1) begin
      bus.core_req_i   = 1'b1;
      bus.core_we_i    = 1'($urandom);
      bus.core_be_i    = 4'($urandom);
      bus.core_addr_i  = $urandom & 32'hFFFF_FFFC;
      bus.core_wdata_i = $urandom;
    end
    if (allow_new && !bus.ctx_valid_i && $urandom_range(0, 2) == 0) begin
      bus.ctx_valid_i = 1'b1;
      bus.ctx_we_i    = 1'($urandom);
      bus.ctx_addr_i  = $urandom & 32'hFFFF_FFFC;
      bus.ctx_wdata_i = $urandom;
    end
    bus.data_gnt_i = ($urandom_range(0, 3) != 0);
    if (mem_pending > 0 && $urandom_range(0, 1) == 1) begin
      bus.data_rvalid_i = 1'b1;
      mem_pending--;
    end else begin
      bus.data_rvalid_i = 1'b0;
    end
    bus.data_rdata_i = $urandom;
    #1;
    if (m_locked) begin
      exp_req = 1'b1;
      exp_ctx = m_owner_ctx;
    end else begin
      exp_req = (tq.size() < MAXO) && (bus.core_req_i || bus.ctx_valid_i);
      exp_ctx = bus.ctx_valid_i && (!bus.core_req_i || wait_cnt >= SLIM);
    end
    chk("rnd_req", 32'(bus.data_req_o), 32'(exp_req));
    if (exp_req) begin
      chk("rnd_addr", bus.data_addr_o, exp_ctx ? bus.ctx_addr_i : bus.core_addr_i);
      chk("rnd_we", 32'(bus.data_we_o), 32'(exp_ctx ? bus.ctx_we_i : bus.core_we_i));
    end
    chk("rnd_core_gnt", 32'(bus.core_gnt_o), 32'(exp_req && bus.data_gnt_i && !exp_ctx));
    chk("rnd_ctx_ready", 32'(bus.ctx_ready_o), 32'(exp_req && bus.data_gnt_i && exp_ctx));
    chk("rnd_outstanding", 32'(bus.outstanding_o), 32'(tq.size()));
    exp_cv = p_rsp && tq.size() > 0 && tq[0].is_core;
    exp_xv = p_rsp && tq.size() > 0 && !tq[0].is_core && tq[0].is_read;
    chk("rnd_core_rvalid", 32'(bus.core_rvalid_o), 32'(exp_cv));
    chk("rnd_ctx_rvalid", 32'(bus.ctx_rvalid_o), 32'(exp_xv));
    if (exp_cv) chk("rnd_core_rdata", bus.core_rdata_o, p_rdata);
    if (exp_xv) chk("rnd_ctx_rdata", bus.ctx_rdata_o, p_rdata);

    hs = exp_req && bus.data_gnt_i;
    rd = exp_ctx ? !bus.ctx_we_i : !bus.core_we_i;
    if (p_rsp && tq.size() > 0) void'(tq.pop_front());
    if (hs) begin
      tq.push_back('{is_core: !exp_ctx, is_read: rd});
      mem_pending++;
    end
    m_locked    = exp_req && !bus.data_gnt_i;
    m_owner_ctx = exp_ctx;
    if (bus.ctx_valid_i && !(hs && exp_ctx)) wait_cnt = (wait_cnt < SLIM) ? wait_cnt + 1 : SLIM;
    else wait_cnt = 0;
    p_rsp     = bus.data_rvalid_i;
    p_rdata   = bus.data_rdata_i;
    drop_core = hs && !exp_ctx;
    drop_ctx  = hs && exp_ctx;
    tick();
    if (drop_core) bus.core_req_i = 1'b0;
    if (drop_ctx) bus.ctx_valid_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{L, L, 4'h0, 32'h0, 32'h0,        L, L, 32'h0, 32'h0,       L,
                L, L, 4'h0, 32'h0, 32'h0, L, L};
    vecs[1] = '{H, H, 4'h3, 32'h1000, 32'h55,    L, L, 32'h0, 32'h0,       H,
                H, H, 4'h3, 32'h1000, 32'h55, H, L};
    vecs[2] = '{L, L, 4'h0, 32'h0, 32'h0,        H, L, 32'h2000, 32'h77,   H,
                H, L, 4'hF, 32'h2000, 32'h77, L, H};
    vecs[3] = '{H, L, 4'hF, 32'h1004, 32'h1,     H, H, 32'h2004, 32'h99,   H,
                H, L, 4'hF, 32'h1004, 32'h1, H, L};
    vecs[4] = '{H, H, 4'h1, 32'h1008, 32'h2,     H, L, 32'h200C, 32'h3,    L,
                H, H, 4'h1, 32'h1008, 32'h2, L, L};
    vecs[5] = '{L, L, 4'h0, 32'h0, 32'h0,        H, H, 32'h3000, 32'hABCD, L,
                H, H, 4'hF, 32'h3000, 32'hABCD, L, L};
    vecs[6] = '{L, H, 4'h5, 32'h4000, 32'h9,     L, H, 32'h5000, 32'h8,    H,
                L, L, 4'h0, 32'h0, 32'h0, L, L};

    // Reset state
    do_reset();
    rst = 1'b1;
    tick();
    chk("rst_req", 32'(bus.data_req_o), 0);
    chk("rst_core_gnt", 32'(bus.core_gnt_o), 0);
    chk("rst_core_rvalid", 32'(bus.core_rvalid_o), 0);
    chk("rst_ctx_rvalid", 32'(bus.ctx_rvalid_o), 0);
    chk("rst_rdata", bus.core_rdata_o, 0);
    chk("rst_outstanding", 32'(bus.outstanding_o), 0);
    chk("rst_err", 32'(bus.err_o), 0);
    rst = 1'b0;

    // Single-cycle arbitration vectors from a clean idle state
    for (int i = 0; i < 7; i++) begin
      do_reset();
      bus.core_req_i = vecs[i].creq; bus.core_we_i = vecs[i].cwe; bus.core_be_i = vecs[i].cbe;
      bus.core_addr_i = vecs[i].caddr; bus.core_wdata_i = vecs[i].cwdata;
      bus.ctx_valid_i = vecs[i].xval; bus.ctx_we_i = vecs[i].xwe;
      bus.ctx_addr_i = vecs[i].xaddr; bus.ctx_wdata_i = vecs[i].xwdata;
      bus.data_gnt_i = vecs[i].gnt;
      #1;
      chk("vec_req", 32'(bus.data_req_o), 32'(vecs[i].req));
      chk("vec_we", 32'(bus.data_we_o), 32'(vecs[i].we));
      chk("vec_be", 32'(bus.data_be_o), 32'(vecs[i].be));
      chk("vec_addr", bus.data_addr_o, vecs[i].addr);
      chk("vec_wdata", bus.data_wdata_o, vecs[i].wdata);
      chk("vec_core_gnt", 32'(bus.core_gnt_o), 32'(vecs[i].cgnt));
      chk("vec_ctx_ready", 32'(bus.ctx_ready_o), 32'(vecs[i].xrdy));
    end

    // Core-only back-to-back reads
    do_reset();
    bus.core_req_i = 1; bus.core_addr_i = 32'h100; bus.data_gnt_i = 1;
    #1;
    chk("core0_addr", bus.data_addr_o, 32'h100);
    chk("core0_gnt", 32'(bus.core_gnt_o), 1);
    tick();
    bus.core_addr_i = 32'h104; bus.data_rvalid_i = 1; bus.data_rdata_i = 32'hA0;
    #1;
    chk("core1_addr", bus.data_addr_o, 32'h104);
    chk("core1_gnt", 32'(bus.core_gnt_o), 1);
    chk("core1_rvalid", 32'(bus.core_rvalid_o), 0);
    tick();
    bus.core_req_i = 0; bus.data_gnt_i = 0; bus.data_rdata_i = 32'hA4;
    #1;
    chk("core2_rvalid", 32'(bus.core_rvalid_o), 1);
    chk("core2_rdata", bus.core_rdata_o, 32'hA0);
    chk("core2_ctx_rvalid", 32'(bus.ctx_rvalid_o), 0);
    chk("core2_outstanding", 32'(bus.outstanding_o), 2);
    tick();
    bus.data_rvalid_i = 0;
    #1;
    chk("core3_rvalid", 32'(bus.core_rvalid_o), 1);
    chk("core3_rdata", bus.core_rdata_o, 32'hA4);
    chk("core3_ctx_rvalid", 32'(bus.ctx_rvalid_o), 0);
    tick();
    #1;
    chk("core4_rvalid", 32'(bus.core_rvalid_o), 0);
    chk("core4_outstanding", 32'(bus.outstanding_o), 0);

    // Conflict: ctx forced through every STARVE_LIMIT+1 cycles
    do_reset();
    bus.core_req_i = 1; bus.core_addr_i = 32'h100;
    bus.ctx_valid_i = 1; bus.ctx_addr_i = 32'h300; bus.data_gnt_i = 1;
    for (int n = 1; n <= 20; n++) begin
      #1;
      chk("conflict_ctx_ready", 32'(bus.ctx_ready_o), (n % (SLIM + 1) == 0) ? 1 : 0);
      chk("conflict_core_gnt", 32'(bus.core_gnt_o), (n % (SLIM + 1) == 0) ? 0 : 1);
      tick();
      bus.data_rvalid_i = 1; bus.data_rdata_i = n;
    end

    // Grant stall holds the ctx address phase
    do_reset();
    bus.ctx_valid_i = 1; bus.ctx_addr_i = 32'h200;
    for (int n = 0; n < 3; n++) begin
      if (n == 1) begin bus.core_req_i = 1; bus.core_addr_i = 32'h100; end
      #1;
      chk("stall_addr", bus.data_addr_o, 32'h200);
      chk("stall_core_gnt", 32'(bus.core_gnt_o), 0);
      chk("stall_ctx_ready", 32'(bus.ctx_ready_o), 0);
      tick();
    end
    bus.data_gnt_i = 1;
    #1;
    chk("stall_rel_addr", bus.data_addr_o, 32'h200);
    chk("stall_rel_ctx_ready", 32'(bus.ctx_ready_o), 1);
    chk("stall_rel_core_gnt", 32'(bus.core_gnt_o), 0);
    tick();
    bus.ctx_valid_i = 0;
    #1;
    chk("stall_core_addr", bus.data_addr_o, 32'h100);
    chk("stall_core_gnt_after", 32'(bus.core_gnt_o), 1);

    // ctx write response is dropped, core read response routed
    do_reset();
    bus.ctx_valid_i = 1; bus.ctx_we_i = 1; bus.ctx_addr_i = 32'h400; bus.ctx_wdata_i = 32'hDEAD;
    bus.data_gnt_i = 1;
    #1;
    chk("wd_we", 32'(bus.data_we_o), 1);
    chk("wd_be", 32'(bus.data_be_o), 32'hF);
    chk("wd_wdata", bus.data_wdata_o, 32'hDEAD);
    tick();
    bus.ctx_valid_i = 0; bus.core_req_i = 1; bus.core_addr_i = 32'h104;
    bus.data_rvalid_i = 1; bus.data_rdata_i = 32'h11;
    #1;
    chk("wd_core_gnt", 32'(bus.core_gnt_o), 1);
    tick();
    bus.core_req_i = 0; bus.data_gnt_i = 0; bus.data_rdata_i = 32'h22;
    #1;
    chk("wd_drop_ctx_rvalid", 32'(bus.ctx_rvalid_o), 0);
    chk("wd_drop_core_rvalid", 32'(bus.core_rvalid_o), 0);
    tick();
    bus.data_rvalid_i = 0;
    #1;
    chk("wd_core_rvalid", 32'(bus.core_rvalid_o), 1);
    chk("wd_core_rdata", bus.core_rdata_o, 32'h22);
    chk("wd_ctx_rvalid", 32'(bus.ctx_rvalid_o), 0);

    // FIFO full blocks new requests, no bypass on the popping cycle
    do_reset();
    bus.core_req_i = 1; bus.data_gnt_i = 1;
    for (int n = 0; n < 4; n++) begin
      bus.core_addr_i = 32'h10 * n;
      #1;
      chk("full_fill_gnt", 32'(bus.core_gnt_o), 1);
      tick();
    end
    bus.core_addr_i = 32'h500;
    #1;
    chk("full_req", 32'(bus.data_req_o), 0);
    chk("full_core_gnt", 32'(bus.core_gnt_o), 0);
    chk("full_outstanding", 32'(bus.outstanding_o), 4);
    tick();
    bus.data_rvalid_i = 1; bus.data_rdata_i = 32'h1;
    #1;
    chk("full_rv_req", 32'(bus.data_req_o), 0);
    tick();
    bus.data_rvalid_i = 0;
    #1;
    chk("full_pop_req", 32'(bus.data_req_o), 0);
    chk("full_pop_rvalid", 32'(bus.core_rvalid_o), 1);
    tick();
    #1;
    chk("full_resume_req", 32'(bus.data_req_o), 1);
    chk("full_resume_gnt", 32'(bus.core_gnt_o), 1);
    chk("full_resume_addr", bus.data_addr_o, 32'h500);
    chk("full_resume_outstanding", 32'(bus.outstanding_o), 3);

    // Spurious response sets a sticky error
    do_reset();
    #1;
    chk("err_clear", 32'(bus.err_o), 0);
    tick();
    bus.data_rvalid_i = 1; bus.data_rdata_i = 32'h5A5A;
    tick();
    bus.data_rvalid_i = 0;
    #1;
    chk("err_no_core_rvalid", 32'(bus.core_rvalid_o), 0);
    chk("err_no_ctx_rvalid", 32'(bus.ctx_rvalid_o), 0);
    tick();
    #1;
    chk("err_set", 32'(bus.err_o), 1);
    repeat (5) tick();
    chk("err_sticky", 32'(bus.err_o), 1);
    chk("err_outstanding", 32'(bus.outstanding_o), 0);
    do_reset();
    #1;
    chk("err_reset", 32'(bus.err_o), 0);

    // Randomized traffic against the rule-level model
    do_reset();
    tq.delete();
    mem_pending = 0; m_locked = 0; m_owner_ctx = 0; wait_cnt = 0; p_rsp = 0; p_rdata = '0;
    for (int c = 0; c < 3000; c++) rnd_cycle(1'b1);
    for (int c = 0; c < 300 && (tq.size() != 0 || mem_pending != 0 || p_rsp ||
                                bus.core_req_i || bus.ctx_valid_i); c++) begin
      rnd_cycle(1'b0);
    end
    #1;
    chk("drain_outstanding", 32'(bus.outstanding_o), 0);
    chk("drain_err", 32'(bus.err_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
